// File: rtl/lcd_pattern_gen_pkg.sv
// Shared display geometry, pattern mode codes and colour-bar palette.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package lcd_defs;

  localparam logic [10:0] H_PIXEL = 11'd800;
  localparam logic [10:0] V_PIXEL = 11'd480;
  localparam logic [10:0] BAR_W   = H_PIXEL / 11'd8;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_DKGREY  = 24'h202020;

  // Bar colour in left-to-right order.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYC stable samples, pulse registered (+1).
// Backpressure: none; rise_o is a single-cycle pulse that must be consumed immediately.
module btn_debounce #(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd660000
) (
  input  logic clk_in,
  input  logic sys_rst_n,
  input  logic btn_in,
  output logic rise_o
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic        rise_q, rise_d;
  logic [19:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any agreement restarts the count.
  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = 20'd0;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DEBOUNCE_CYC - 20'd1) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= 20'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source for the LCD timing controller (bars/checker/gradient/bouncing box).
// Latency: pix_data is registered, exactly 1 cycle after data_req/pix_x/pix_y.
// Backpressure: none; every request is answered the next cycle, mode switches only at frame end.
module lcd_pattern_gen
  import lcd_defs::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd660000,
  parameter logic [10:0] BOX_SIZE     = 11'd64,
  parameter logic [10:0] BOX_STEP     = 11'd2,
  parameter int          CHK_SHIFT    = 5
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic        data_req,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        mode_btn,
  output logic [23:0] pix_data,
  output logic [1:0]  mode,
  output logic        frame_end
);

  localparam logic [10:0] BX_MAX = H_PIXEL - BOX_SIZE;
  localparam logic [10:0] BY_MAX = V_PIXEL - BOX_SIZE;

  logic        btn_rise;
  logic [23:0] pix_data_q, pix_data_d;
  logic        frame_end_q, frame_end_d;
  mode_e       mode_q, mode_d;
  logic [1:0]  pend_q, pend_d;
  logic [10:0] bx_q, bx_d, by_q, by_d;
  dir_e        dx_q, dx_d, dy_q, dy_d;

  logic [10:0] row;
  logic [10:0] bar_q;
  logic [2:0]  bar_idx;
  logic        in_box;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk_in    (clk_in),
    .sys_rst_n (sys_rst_n),
    .btn_in    (mode_btn),
    .rise_o    (btn_rise)
  );

  // One axis of the bounce: step, clamp at the wall and reverse. Returns {dir, pos}.
  function automatic logic [11:0] axis_step(input logic [10:0] pos, input dir_e dir,
                                            input logic [10:0] lim);
    logic [10:0] nx;
    logic [11:0] r;
    if (dir == DIR_POS) begin
      nx = pos + BOX_STEP;
      r  = (nx > lim) ? {DIR_NEG, lim} : {DIR_POS, nx};
    end else begin
      r  = (pos < BOX_STEP) ? {DIR_POS, 11'd0} : {DIR_NEG, pos - BOX_STEP};
    end
    return r;
  endfunction

  // Pixel geometry helpers: controller rows are 1-based, bar index saturates at the last bar.
  always_comb begin
    row     = pix_y - 11'd1;
    bar_q   = pix_x / BAR_W;
    bar_idx = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
    in_box  = (pix_x >= bx_q) && (pix_x < bx_q + BOX_SIZE) &&
              (row >= by_q) && (row < by_q + BOX_SIZE);
  end

  // Pattern mux, frame boundary detection, pending-mode accumulation and box motion.
  always_comb begin
    logic [11:0] ax;
    logic [11:0] ay;
    pix_data_d  = 24'h0;
    frame_end_d = data_req && (pix_y == V_PIXEL) && (pix_x == H_PIXEL - 11'd1);
    pend_d      = pend_q + {1'b0, btn_rise};
    mode_d      = mode_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    ax          = axis_step(bx_q, dx_q, BX_MAX);
    ay          = axis_step(by_q, dy_q, BY_MAX);

    if (data_req) begin
      case (mode_q)
        MODE_BARS:  pix_data_d = bar_colour(bar_idx);
        MODE_CHECK: pix_data_d = (pix_x[CHK_SHIFT] ^ row[CHK_SHIFT]) ? COL_WHITE : COL_BLACK;
        MODE_GRAD:  pix_data_d = {pix_x[9:2], row[8:1], ~pix_x[9:2]};
        default:    pix_data_d = in_box ? COL_RED : COL_DKGREY;
      endcase
    end

    // The pending value sampled here excludes a press landing this same cycle.
    if (frame_end_q) begin
      mode_d = mode_e'(pend_q);
      bx_d   = ax[10:0];
      dx_d   = dir_e'(ax[11]);
      by_d   = ay[10:0];
      dy_d   = dir_e'(ay[11]);
    end
  end

  // State registers with synchronous reset; box restarts at the origin heading +x,+y.
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      pix_data_q  <= 24'h0;
      frame_end_q <= 1'b0;
      mode_q      <= MODE_BARS;
      pend_q      <= 2'd0;
      bx_q        <= 11'd0;
      by_q        <= 11'd0;
      dx_q        <= DIR_POS;
      dy_q        <= DIR_POS;
    end else begin
      pix_data_q  <= pix_data_d;
      frame_end_q <= frame_end_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign mode      = mode_q;
  assign frame_end = frame_end_q;

endmodule
